imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Upstream program loader for the 8-bit RISC-V pipeline top level. It takes a byte stream from a host link, such as a UART receiver, and assembles 32-bit little-endian instructions. It drives the top level's instruction-memory write port (rw, PC_write, instruction_in) and holds the core in reset while loading. When the load completes, it releases the core to run.

Parameters:
ADDR_W, 10, instruction-memory address width (matches PC_write)
BASE_ADDR, 1, address of the first loaded instruction
CLEAR_CYCLES, 8, cycles reset_IF_memory is asserted before loading
TIMEOUT, 1000, maximum idle cycles between bytes after start before error

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; one clock domain
start  in  1  1-cycle pulse to begin a load; accepted only in IDLE, DONE or ERROR
byte_valid  in  1  byte_data is valid this cycle (single-cycle strobe; no backpressure)
byte_data  in  8  stream byte
core_reset  out  1  reset to the pipeline top level
reset_IF_memory  out  1  instruction-memory clear to the top level
rw  out  1  0 = write instruction memory, 1 = read/run
PC_write  out  ADDR_W  write address
instruction_in  out  32  write data
busy  out  1  load in progress
done  out  1  load finished, core running
error  out  1  load aborted

Behaviour:
- Stream format:
  - Count low byte, then count high byte. Only bits [ADDR_W-9:0] of the high byte are legal; any other bit set is an error.
  - Then count×4 instruction bytes, LSB first.
- FSM states: IDLE, CLEAR, HDR_LO, HDR_HI, WORD, COMMIT, RUN(DONE), ERROR.
- Reset → IDLE. Reset values:
  - core_reset=1, reset_IF_memory=0, rw=1, PC_write=0, instruction_in=0.
  - busy=0, done=0, error=0.
  - All internal counters and the shadow word are 0.
- IDLE: start → CLEAR. Clear busy/done/error on the same edge; set busy=1.
- CLEAR:
  - reset_IF_memory=1 for exactly CLEAR_CYCLES cycles.
  - rw=0, PC_write=BASE_ADDR-1, instruction_in=0.
  - byte_valid is ignored.
  - Then go to HDR_LO.
- HDR_LO / HDR_HI: latch the count bytes.
  - Illegal high bits → ERROR.
  - count > 2^ADDR_W − BASE_ADDR → ERROR.
  - count==0 → RUN directly.
- WORD:
  - Shift bytes into a 32-bit shadow register with a 2-bit byte index.
  - Partial words are never visible on instruction_in.
  - On acceptance of byte 3: next edge loads PC_write ← current address and instruction_in ← shadow simultaneously; go to COMMIT.
- COMMIT:
  - Outputs are stable for ≥1 cycle with rw=0 (memory writes every rw=0 edge; repeated writes of the same word are harmless).
  - Then increment the word counter. If all words are loaded → RUN, else → WORD.
  - A byte_valid during COMMIT is accepted as byte 0 of the next word.
- RUN (done):
  - rw=1, core_reset=0, busy=0, done=1.
  - PC_write/instruction_in hold their last values.
  - Stays until start or reset.
- Timeout: while in HDR_LO, HDR_HI or WORD, a cycle counter counts cycles without byte_valid. Reaching TIMEOUT → ERROR.
- ERROR: core_reset=1, rw=1, error=1, busy=0. Exit only by start (→ CLEAR) or reset.
- start while busy is ignored.
- A byte_valid in IDLE, RUN or ERROR is dropped.
- Latency from the final byte to core_reset deassertion is 3 edges.
- Reset mid-load aborts immediately to IDLE; memory contents are undefined, and a reload is required.

Decomposition:
- Shared package (imem_loader_pkg): state encoding constants and the byte-per-word constant (4).
- Sub-module word_assembler: shadow register, byte index and word_ready pulse.

Test Plan:
- Reset, then start, then stream 02 00 | 83 80 02 00 | 03 81 02 00:
  - reset_IF_memory is high for 8 cycles.
  - PC_write=1 with instruction_in=0x00028083, then PC_write=2 with instruction_in=0x00028103.
  - Then rw=1, core_reset=0, done=1.
- Stream count 00 00 → no writes, RUN within 2 edges of the high byte, done=1.
- Stream count 00 04 (1024 > 1023) → error=1, core_reset stays 1, rw=1.
- Send 1 word with 2 bytes, then idle 1000 cycles → error=1. Then start plus a valid stream → successful load.
- Pulse reset mid-word (after 2 bytes) → all outputs at reset values next edge. Later start → fresh load from PC_write=1.
- start during WORD → ignored; the load completes normally with the correct word count.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state
// encoding and the byte-per-word geometry of the little-endian stream.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_WORD,
    ST_COMMIT,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects stream bytes LSB first into a 32-bit shadow word and pulses
// wordReady for one cycle after the fourth byte of a word lands.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_byteAccept,
  input  logic [7:0]  i_byteData,
  output logic [31:0] o_shadowWord,
  output logic        o_wordReady
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [31:0]           r_shadow;
  logic [BYTE_IDX_W-1:0] r_byteIdx;
  logic                  r_wordReady;

  // Shift each accepted byte in from the top so the first byte ends up in
  // bits [7:0]; the index wraps naturally to start the next word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shadow    <= 32'd0;
      r_byteIdx   <= '0;
      r_wordReady <= 1'b0;
    end else begin
      r_wordReady <= 1'b0;
      if (i_clear) begin
        r_shadow  <= 32'd0;
        r_byteIdx <= '0;
      end else if (i_byteAccept) begin
        r_shadow    <= {i_byteData, r_shadow[31:8]};
        r_byteIdx   <= r_byteIdx + 1'b1;
        r_wordReady <= (r_byteIdx == LAST_IDX);
      end
    end
  end

  assign o_shadowWord = r_shadow;
  assign o_wordReady  = r_wordReady;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: clears instruction memory, reads a 16-bit
// word count, writes that many little-endian words starting at BASE_ADDR
// while holding the core in reset, then releases the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int BASE_ADDR    = 1,
  parameter int CLEAR_CYCLES = 8,
  parameter int TIMEOUT      = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              core_reset,
  output logic              reset_IF_memory,
  output logic              rw,
  output logic [ADDR_W-1:0] PC_write,
  output logic [31:0]       instruction_in,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W     = ADDR_W + 1;
  localparam int CLR_W     = $clog2(CLEAR_CYCLES + 1);
  localparam int TMO_W     = $clog2(TIMEOUT + 1);
  localparam int MAX_COUNT = (1 << ADDR_W) - BASE_ADDR;
  localparam int HI_LEGAL  = ADDR_W - 8;

  state_t            r_state;
  logic [CLR_W-1:0]  r_clearCnt;
  logic [TMO_W-1:0]  r_idleCnt;
  logic [7:0]        r_countLo;
  logic [CNT_W-1:0]  r_wordTotal;
  logic [CNT_W-1:0]  r_wordCnt;
  logic [ADDR_W-1:0] r_addr;

  logic [15:0] w_fullCount;
  logic        w_hiIllegal;
  logic        w_tooMany;
  logic        w_lastWord;
  logic        w_accept;
  logic        w_idleExpired;
  logic [31:0] w_shadow;
  logic        w_wordReady;

  assign w_fullCount   = {byte_data, r_countLo};
  assign w_hiIllegal   = (byte_data >> HI_LEGAL) != 8'd0;
  assign w_tooMany     = 32'(w_fullCount) > 32'(MAX_COUNT);
  assign w_lastWord    = (r_wordCnt + CNT_W'(1)) == r_wordTotal;
  assign w_idleExpired = !byte_valid && (r_idleCnt == TMO_W'(TIMEOUT - 1));

  // Bytes only feed the assembler while words are expected; a byte arriving
  // during the last commit has no word to belong to and is dropped.
  assign w_accept = byte_valid &&
                    ((r_state == ST_WORD) || ((r_state == ST_COMMIT) && !w_lastWord));

  word_assembler u_assembler (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (r_state == ST_CLEAR),
    .i_byteAccept (w_accept),
    .i_byteData   (byte_data),
    .o_shadowWord (w_shadow),
    .o_wordReady  (w_wordReady)
  );

  // Load sequencer with all outputs registered; the write port only ever
  // shows complete words, updated address and data on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      core_reset      <= 1'b1;
      reset_IF_memory <= 1'b0;
      rw              <= 1'b1;
      PC_write        <= '0;
      instruction_in  <= 32'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      r_clearCnt      <= '0;
      r_idleCnt       <= '0;
      r_countLo       <= 8'd0;
      r_wordTotal     <= '0;
      r_wordCnt       <= '0;
      r_addr          <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (start) begin
            r_state         <= ST_CLEAR;
            busy            <= 1'b1;
            done            <= 1'b0;
            error           <= 1'b0;
            core_reset      <= 1'b1;
            reset_IF_memory <= 1'b1;
            rw              <= 1'b0;
            PC_write        <= ADDR_W'(BASE_ADDR - 1);
            instruction_in  <= 32'd0;
            r_clearCnt      <= '0;
            r_idleCnt       <= '0;
            r_countLo       <= 8'd0;
            r_wordTotal     <= '0;
            r_wordCnt       <= '0;
            r_addr          <= ADDR_W'(BASE_ADDR);
          end
        end
        ST_CLEAR: begin
          if (r_clearCnt == CLR_W'(CLEAR_CYCLES - 1)) begin
            reset_IF_memory <= 1'b0;
            r_idleCnt       <= '0;
            r_state         <= ST_HDR_LO;
          end else begin
            r_clearCnt <= r_clearCnt + 1'b1;
          end
        end
        ST_HDR_LO: begin
          if (byte_valid) begin
            r_countLo <= byte_data;
            r_idleCnt <= '0;
            r_state   <= ST_HDR_HI;
          end else if (w_idleExpired) begin
            rw      <= 1'b1;
            busy    <= 1'b0;
            error   <= 1'b1;
            r_state <= ST_ERROR;
          end else begin
            r_idleCnt <= r_idleCnt + 1'b1;
          end
        end
        ST_HDR_HI: begin
          if (byte_valid) begin
            r_idleCnt <= '0;
            if (w_hiIllegal || w_tooMany) begin
              rw      <= 1'b1;
              busy    <= 1'b0;
              error   <= 1'b1;
              r_state <= ST_ERROR;
            end else if (w_fullCount == 16'd0) begin
              rw         <= 1'b1;
              core_reset <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              r_state    <= ST_RUN;
            end else begin
              r_wordTotal <= w_fullCount[CNT_W-1:0];
              r_state     <= ST_WORD;
            end
          end else if (w_idleExpired) begin
            rw      <= 1'b1;
            busy    <= 1'b0;
            error   <= 1'b1;
            r_state <= ST_ERROR;
          end else begin
            r_idleCnt <= r_idleCnt + 1'b1;
          end
        end
        ST_WORD: begin
          if (w_wordReady) begin
            PC_write       <= r_addr;
            instruction_in <= w_shadow;
            r_idleCnt      <= '0;
            r_state        <= ST_COMMIT;
          end else if (byte_valid) begin
            r_idleCnt <= '0;
          end else if (w_idleExpired) begin
            rw      <= 1'b1;
            busy    <= 1'b0;
            error   <= 1'b1;
            r_state <= ST_ERROR;
          end else begin
            r_idleCnt <= r_idleCnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_wordCnt <= r_wordCnt + 1'b1;
          r_addr    <= r_addr + 1'b1;
          r_idleCnt <= '0;
          if (w_lastWord) begin
            rw         <= 1'b1;
            core_reset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            r_state    <= ST_RUN;
          end else begin
            r_state <= ST_WORD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a header vector table plus
// hand-written sequences, with every memory write checked against a
// scoreboard of expected (address, word) pairs.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              core_reset;
  logic              reset_IF_memory;
  logic              rw;
  logic [ADDR_W-1:0] PC_write;
  logic [31:0]       instruction_in;
  logic              busy;
  logic              done;
  logic              error;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } wrExp_t;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       expErr;
  } hdrVec_t;

  wrExp_t            expQ[$];
  logic [ADDR_W-1:0] expPc;
  logic [ADDR_W-1:0] prevPc;
  logic [31:0]       prevInstr;
  int                nChecks = 0;
  int                nFails  = 0;

  imem_loader #(
    .ADDR_W       (ADDR_W),
    .BASE_ADDR    (1),
    .CLEAR_CYCLES (8),
    .TIMEOUT      (1000)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .core_reset      (core_reset),
    .reset_IF_memory (reset_IF_memory),
    .rw              (rw),
    .PC_write        (PC_write),
    .instruction_in  (instruction_in),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  // Free-running 100 MHz clock
  always #5 clock = ~clock;

  // Hard stop in case a sequence never returns
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation still running at 5 ms, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // A write is any new (address, data) pair presented with rw=0 outside the
  // clear phase; each must match the oldest outstanding expectation.
  always @(negedge clock) begin
    wrExp_t e;
    if (reset === 1'b0 && rw === 1'b0 && reset_IF_memory === 1'b0 &&
        {PC_write, instruction_in} !== {prevPc, prevInstr}) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected write: PC_write=%0d instruction_in=0x%0h, required no write",
                 PC_write, instruction_in);
      end else begin
        e = expQ.pop_front();
        checkOutput("write PC_write", 32'(PC_write), 32'(e.pc));
        checkOutput("write instruction_in", instruction_in, e.instr);
      end
    end
    prevPc    = PC_write;
    prevInstr = instruction_in;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic s);
    byte_valid = v;
    byte_data  = d;
    start      = s;
    tick();
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " core_reset"}, 32'(core_reset), 32'd1);
    checkOutput({tag, " reset_IF_memory"}, 32'(reset_IF_memory), 32'd0);
    checkOutput({tag, " rw"}, 32'(rw), 32'd1);
    checkOutput({tag, " PC_write"}, 32'(PC_write), 32'd0);
    checkOutput({tag, " instruction_in"}, instruction_in, 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " error"}, 32'(error), 32'd0);
  endtask

  // Pulse start and measure how long memory clear is held; junkValid
  // streams bytes during the clear that must be ignored.
  task automatic startLoad(input logic junkValid);
    int clearLen;
    clearLen = 0;
    expPc    = ADDR_W'(1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("busy after start", 32'(busy), 32'd1);
    checkOutput("rw after start", 32'(rw), 32'd0);
    for (int i = 0; i < 50; i++) begin
      if (!reset_IF_memory) break;
      clearLen++;
      applyStimulus(junkValid, 8'hA5, 1'b0);
    end
    checkOutput("reset_IF_memory cycles", 32'(clearLen), 32'd8);
  endtask

  // Queue the expected write, then stream the word LSB first; an optional
  // start pulse rides along with byte startIdx.
  task automatic sendWord(input logic [31:0] w, input int gap, input int startIdx);
    logic [31:0] wv;
    wv = w;
    expQ.push_back('{pc: expPc, instr: wv});
    expPc = expPc + 1'b1;
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b1, wv[8*b +: 8], (b == startIdx));
      if (b < 3) idleCycles(gap);
    end
  endtask

  task automatic waitSettled(input int budget);
    int k;
    for (k = 0; k < budget && !(done || error); k++) tick();
    checkOutput("settled within cycle budget", 32'(k < budget), 32'd1);
  endtask

  task automatic checkFinal(input string tag, input logic expErr);
    checkOutput({tag, " done"}, 32'(done), 32'(!expErr));
    checkOutput({tag, " error"}, 32'(error), 32'(expErr));
    checkOutput({tag, " core_reset"}, 32'(core_reset), 32'(expErr));
    checkOutput({tag, " rw"}, 32'(rw), 32'd1);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " pending writes"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    hdrVec_t vecs[7];
    int      cnt;

    vecs[0] = '{lo: 8'h00, hi: 8'h00, expErr: 1'b0};
    vecs[1] = '{lo: 8'h00, hi: 8'h04, expErr: 1'b1};
    vecs[2] = '{lo: 8'h00, hi: 8'h80, expErr: 1'b1};
    vecs[3] = '{lo: 8'h01, hi: 8'h00, expErr: 1'b0};
    vecs[4] = '{lo: 8'h03, hi: 8'h00, expErr: 1'b0};
    vecs[5] = '{lo: 8'h01, hi: 8'hFC, expErr: 1'b1};
    vecs[6] = '{lo: 8'hFF, hi: 8'h03, expErr: 1'b0};

    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    prevPc     = '0;
    prevInstr  = 32'd0;
    expPc      = ADDR_W'(1);
    repeat (3) tick();
    checkResetValues("reset");
    reset = 1'b0;
    tick();
    checkResetValues("idle");

    // Bytes while idle are dropped
    applyStimulus(1'b1, 8'h02, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("idle ignores bytes busy", 32'(busy), 32'd0);

    $display("[TB] two-word load with 3-edge release latency");
    startLoad(1'b1);
    applyStimulus(1'b1, 8'h02, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    sendWord(32'h00028083, 0, -1);
    sendWord(32'h00028103, 0, -1);
    checkOutput("latency edge1 core_reset", 32'(core_reset), 32'd1);
    tick();
    checkOutput("latency edge2 core_reset", 32'(core_reset), 32'd1);
    checkOutput("commit rw", 32'(rw), 32'd0);
    checkOutput("commit PC_write", 32'(PC_write), 32'd2);
    tick();
    checkFinal("two-word", 1'b0);

    // Bytes in RUN are dropped and the core keeps running
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    idleCycles(3);
    checkOutput("run ignores bytes done", 32'(done), 32'd1);
    checkOutput("run holds PC_write", 32'(PC_write), 32'd2);

    $display("[TB] header vector table");
    foreach (vecs[i]) begin
      startLoad(1'b0);
      applyStimulus(1'b1, vecs[i].lo, 1'b0);
      applyStimulus(1'b1, vecs[i].hi, 1'b0);
      cnt = {vecs[i].hi, vecs[i].lo};
      if (!vecs[i].expErr) begin
        if (cnt == 0) begin
          checkOutput("zero count done immediately", 32'(done), 32'd1);
        end
        for (int w = 0; w < cnt; w++) sendWord($urandom, $urandom_range(0, 1), -1);
      end else begin
        checkOutput("bad header error immediately", 32'(error), 32'd1);
      end
      waitSettled(20);
      checkFinal($sformatf("vec%0d", i), vecs[i].expErr);
    end

    // Bytes in ERROR are dropped
    startLoad(1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    idleCycles(2);
    checkFinal("error ignores bytes", 1'b1);

    $display("[TB] idle timeout mid-word then clean reload");
    startLoad(1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h13, 1'b0);
    applyStimulus(1'b1, 8'h05, 1'b0);
    idleCycles(990);
    checkOutput("no timeout before limit", 32'(error), 32'd0);
    checkOutput("busy before limit", 32'(busy), 32'd1);
    waitSettled(30);
    checkFinal("timeout", 1'b1);
    startLoad(1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    sendWord(32'h00500513, 1, -1);
    waitSettled(20);
    checkFinal("reload after timeout", 1'b0);

    $display("[TB] reset mid-word then fresh load");
    startLoad(1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hB3, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    checkResetValues("mid-word reset");
    reset = 1'b0;
    idleCycles(2);
    checkOutput("idle after reset busy", 32'(busy), 32'd0);
    startLoad(1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    sendWord(32'h002081B3, 0, -1);
    waitSettled(20);
    checkFinal("fresh load", 1'b0);

    $display("[TB] start while busy is ignored");
    startLoad(1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b1);
    sendWord(32'hDEADBEEF, 0, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("busy after ignored start", 32'(busy), 32'd1);
    checkOutput("reset_IF_memory after ignored start", 32'(reset_IF_memory), 32'd0);
    sendWord(32'h12345678, 1, 3);
    waitSettled(20);
    checkFinal("start during word", 1'b0);
    checkOutput("final PC_write", 32'(PC_write), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
